ball_vertical_counter: RTL and testbench
========================================

# ball_vertical_counter

Ball vertical position counter for the Pong core. It consumes the 4-bit vertical velocity nibble produced by the ball vertical move logic, applies it once per frame at the start of vertical blank, and counts video lines to generate the ball vertical video window (`vvid`) and the ball-relative line number. `vvid` and `vblank` feed back into the velocity logic's direction flip-flop. `vball_line` drives the paddle hit-segment decode.

## Interface
Parameters:
- `FRAME_TRIM`, default 8'd10: constant added at each vblank adjustment. It equals 256 minus the active lines per frame (246), so a zero velocity gives zero net drift.
- `SERVE_POS`, default 8'h80: counter value loaded on reset and on serve.

Ports:
- `clk7_159`  in  1  system clock; all state changes on the rising edge.
- `_reset`  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- `line_tick`  in  1  one-cycle strobe, once per video line (from the horizontal counter).
- `vblank`  in  1  vertical blank level, synchronous to `clk7_159`; only sampled on `line_tick` cycles.
- `ab, bb, cb, db`  in  1 each  velocity nibble `v = {db,cb,bb,ab}`, 4-bit two's complement (−8..+7), sampled on the vblank-entry tick.
- `serve`  in  1  level or pulse; recentres the ball vertically.
- `attract`  in  1  attract-mode flag; used only when `BALL_VATTRACT_FREEZE_EN` is defined.
- `vvid`  out  1  registered; high while the ball occupies the current line.
- `vball_line`  out  4  registered; line index within the 16-line ball window, valid while `vvid` is high.

## Operation
- Internal state:
  - `vcnt[7:0]`, the counter.
  - `phase`, a 2-state FSM with states ACTIVE and BLANK.
- Priority, highest first: `_reset` low, then `serve`, then `line_tick` processing.
- Reset:
  - `vcnt` ← `SERVE_POS`.
  - `phase` ← ACTIVE.
  - `vvid` ← 0, `vball_line` ← 0.
- `serve` high on any clock: `vcnt` ← `SERVE_POS` and `phase` is unchanged. A `line_tick` in the same cycle is ignored (no count, no adjustment).
- On a `line_tick` with no serve:
  - ACTIVE and `vblank`=0: `vcnt` ← `vcnt`+1, mod 256.
  - ACTIVE and `vblank`=1: `vcnt` ← `vcnt` + `FRAME_TRIM` + sext8(v), mod 256; `phase` ← BLANK.
  - BLANK and `vblank`=1: hold.
  - BLANK and `vblank`=0: `vcnt` ← `vcnt`+1; `phase` ← ACTIVE. The first active line counts.
- Net per-frame drift is +v lines, given 246 active and 16 blank lines per frame. A positive v moves the ball window earlier (upward).
- Output registers, updated every clock from the pre-update state:
  - `vvid` ← (`vcnt[7:4]`==4'hF) && (`phase`==ACTIVE).
  - `vball_line` ← `vcnt[3:0]`.
- The window is counter values 0xF0..0xFF, i.e. 16 lines. Wrap from 0xFF to 0x00 ends the window with no special case.
- No `line_tick` and no serve: all state holds.

## Timing
- Counter update latency: the edge on which `line_tick` is sampled.
- `vvid` and `vball_line` lag `vcnt` by exactly one clock. They are stable for the whole line except its first clock.
- `vblank` changing between ticks has no effect until the next tick.
- Reset asserted mid-frame takes effect on the next edge regardless of `line_tick`. The outputs read 0 on the following cycle.
- `serve` held for several cycles holds `vcnt` at `SERVE_POS` for its whole duration.

## Configuration
- Macro: `BALL_VATTRACT_FREEZE_EN`.
- Defined: while `attract`=1, the vblank adjustment uses v=0 (`FRAME_TRIM` only), so the ball has no vertical drift during attract.
- Undefined: `attract` is ignored (unused input) and the velocity always applies.

## Test plan
- Reset, then 112 ticks with `vblank`=0 → `vcnt`=0xF0; `vvid` rises one clock after tick 112 with `vball_line`=0; it stays high for 16 ticks and falls one clock after the tick that wraps `vcnt` to 0x00.
- Run full frames (246 active + 16 blank lines) with v=4'b0000 → `vcnt` at each frame's first active line is identical; the `vvid` start line is constant.
- v=4'b0011 → the `vvid` start moves 3 lines earlier per frame. v=4'b1101 (−3) → 3 lines later per frame. Run across the 0xFF→0x00 wrap with no glitch.
- `serve` pulsed coincident with the vblank-entry `line_tick` → `vcnt`=0x80 next clock, no adjustment applied, `phase` stays ACTIVE, then the next tick enters BLANK normally.
- `_reset` low during BLANK with `vvid`=1 earlier → next clock `vcnt`=0x80, `phase`=ACTIVE; one clock later `vvid`=0, `vball_line`=0.
- With `BALL_VATTRACT_FREEZE_EN` defined, `attract`=1 and v=+5 → zero drift over 3 frames. Without the macro, the same stimulus gives +5 lines per frame.

Source files
------------

// File: rtl/ball_vertical_counter.sv
// Ball vertical position counter: applies the per-frame velocity at vblank entry and
// generates the 16-line ball window. Optional macro BALL_VATTRACT_FREEZE_EN zeroes drift in attract.
module ball_vertical_counter #(
  parameter logic [7:0] FRAME_TRIM = 8'd10,
  parameter logic [7:0] SERVE_POS  = 8'h80
) (
  input  logic       clk7_159,
  input  logic       _reset,
  input  logic       line_tick,
  input  logic       vblank,
  input  logic       ab,
  input  logic       bb,
  input  logic       cb,
  input  logic       db,
  input  logic       serve,
  input  logic       attract,
  output logic       vvid,
  output logic [3:0] vball_line
);

  typedef enum logic {ACTIVE = 1'b0, BLANK = 1'b1} phase_t;

  phase_t            r_phase;
  phase_t            w_phase_nxt;
  logic [7:0]        r_vcnt;
  logic [7:0]        w_vcnt_nxt;
  logic [7:0]        w_vcnt_adj;
  logic signed [3:0] w_vel;
  logic              r_vvid;
  logic [3:0]        r_vball_line;

  function automatic logic signed [7:0] sext8(input logic signed [3:0] x);
    return {{4{x[3]}}, x};
  endfunction

`ifdef BALL_VATTRACT_FREEZE_EN
  assign w_vel = attract ? 4'sd0 : {db, cb, bb, ab};
`else
  logic w_unused_attract;
  assign w_unused_attract = attract;
  assign w_vel = {db, cb, bb, ab};
`endif

  // Trim cancels the 246-line active count so only the velocity moves the window.
  assign w_vcnt_adj = r_vcnt + FRAME_TRIM + sext8(w_vel);

  always_comb begin
    w_vcnt_nxt  = r_vcnt;
    w_phase_nxt = r_phase;
    if (serve) begin
      w_vcnt_nxt = SERVE_POS;
    end else if (line_tick) begin
      unique case (r_phase)
        ACTIVE: begin
          if (vblank) begin
            w_vcnt_nxt  = w_vcnt_adj;
            w_phase_nxt = BLANK;
          end else begin
            w_vcnt_nxt = r_vcnt + 8'd1;
          end
        end
        BLANK: begin
          if (!vblank) begin
            w_vcnt_nxt  = r_vcnt + 8'd1;
            w_phase_nxt = ACTIVE;
          end
        end
        default: w_phase_nxt = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      r_vcnt  <= SERVE_POS;
      r_phase <= ACTIVE;
    end else begin
      r_vcnt  <= w_vcnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Outputs decode the pre-update counter, so they trail it by one clock.
  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      r_vvid       <= 1'b0;
      r_vball_line <= 4'd0;
    end else begin
      r_vvid       <= (r_vcnt[7:4] == 4'hF) && (r_phase == ACTIVE);
      r_vball_line <= r_vcnt[3:0];
    end
  end

  assign vvid       = r_vvid;
  assign vball_line = r_vball_line;

endmodule

// File: tb/tb_ball_vertical_counter.sv
// Scoreboard bench for ball_vertical_counter: line/frame model plus window-drift measurement.
module tb_ball_vertical_counter;

`ifdef BALL_VATTRACT_FREEZE_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       vb = 1'b0;
  logic       srv = 1'b0;
  logic       att = 1'b0;
  logic [3:0] v = 4'd0;
  logic       vvid;
  logic [3:0] vline;

  always #5 clk = ~clk;

  ball_vertical_counter dut (
    .clk7_159  (clk),
    ._reset    (rst_n),
    .line_tick (tick),
    .vblank    (vb),
    .ab        (v[0]),
    .bb        (v[1]),
    .cb        (v[2]),
    .db        (v[3]),
    .serve     (srv),
    .attract   (att),
    .vvid      (vvid),
    .vball_line(vline)
  );

  int         total = 0;
  int         bad = 0;
  logic [4:0] exp_q[$];
  int         rise_q[$];
  int         m_cnt = 128;
  bit         m_blank = 1'b0;
  bit         rec_on = 1'b0;
  int         cyc = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int veff(input logic [3:0] vv, input logic a);
    int s;
    s = (vv >= 4'd8) ? int'(vv) - 16 : int'(vv);
    if (FREEZE && a) s = 0;
    return s;
  endfunction

  // One clock of stimulus; the reference model predicts the outputs after the next edge.
  task automatic step(input logic r, input logic t, input logic b, input logic s,
                      input logic a, input logic [3:0] vv);
    logic [4:0] e;
    @(negedge clk);
    rst_n = r; tick = t; vb = b; srv = s; att = a; v = vv;
    if (!r) e = 5'd0;
    else    e = {(m_cnt >= 240) && !m_blank, 4'(m_cnt % 16)};
    exp_q.push_back(e);
    if (!r) begin
      m_cnt = 128; m_blank = 1'b0;
    end else if (s) begin
      m_cnt = 128;
    end else if (t) begin
      if (!m_blank && !b) m_cnt = (m_cnt + 1) % 256;
      else if (!m_blank && b) begin
        m_cnt = (m_cnt + 10 + veff(vv, a)) % 256;
        m_blank = 1'b1;
      end else if (m_blank && !b) begin
        m_cnt = (m_cnt + 1) % 256;
        m_blank = 1'b0;
      end
    end
  endtask

  task automatic line(input logic b, input logic [3:0] vv, input logic a, input logic s);
    step(1'b1, 1'b1, b, s, a, vv);
    step(1'b1, 1'b0, b, 1'b0, a, vv);
  endtask

  task automatic frame(input logic [3:0] vv, input logic a);
    for (int i = 0; i < 246; i++) line(1'b0, vv, a, 1'b0);
    for (int i = 0; i < 16; i++)  line(1'b1, vv, a, 1'b0);
  endtask

  // Monitor: pops one prediction per edge and records window rises.
  initial begin
    logic [4:0] e;
    logic       prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("vvid", 16'(vvid), 16'(e[4]));
        check("vball_line", 16'(vline), 16'(e[3:0]));
      end
      if (rec_on && vvid === 1'b1 && prev !== 1'b1) rise_q.push_back(cyc);
      prev = vvid;
    end
  end

  localparam int NF = 12;
  logic [3:0] dv [NF] = '{4'd0, 4'd0, 4'd0, 4'd3, 4'd3, 4'd3,
                          4'd13, 4'd13, 4'd13, 4'd5, 4'd5, 4'd5};
  bit         da [NF] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    bit b_r;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    rec_on = 1'b1;
    for (int f = 0; f < NF; f++) frame(dv[f], da[f]);
    rec_on = 1'b0;

    // Serve coincident with the vblank-entry tick, then normal blank entry.
    for (int i = 0; i < 246; i++) line(1'b0, 4'd7, 1'b0, 1'b0);
    line(1'b1, 4'd7, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) line(1'b1, 4'd7, 1'b0, 1'b0);

    // Walk through the window, then reset during blank.
    for (int i = 0; i < 246; i++) line(1'b0, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) line(1'b1, 4'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    for (int i = 0; i < 20; i++) line(1'b0, 4'd2, 1'b0, 1'b0);

    // Randomised traffic, including held serve, mid-line vblank changes and resets.
    b_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) b_r = ~b_r;
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0), b_r,
           ($urandom_range(0, 79) == 0) || (i % 1000 < 4), 1'(($urandom_range(0, 1))),
           4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    check("rise_count", 16'(rise_q.size()), 16'(NF));
    if (rise_q.size() == NF) begin
      for (int k = 0; k < NF - 1; k++)
        check($sformatf("rise_delta_%0d", k), 16'(rise_q[k+1] - rise_q[k]),
              16'(524 - 2 * veff(dv[k], da[k])));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
